llc_read_engine: RTL and testbench

Synthesizable, parametrised processor-read engine for the last-level cache. It owns the tag, MESI and tree-PLRU arrays for a WAYS-way, SETS-set cache and services one processor read at a time: hit, fill into a vacant way, or PLRU eviction with writeback of a Modified victim. It sits between the processor request port, the shared system bus (with snoop result) and the L1 message channel. A sibling coherence path writes line state through a side port.

---
 rtl/llc_read_engine.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_llc_read_engine.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_read_engine.sv
// llc_read_engine
//   Processor-read engine for the last-level cache. Owns the tag, MESI and
//   tree-PLRU arrays of a WAYS-way, SETS-set cache and services one read at
//   a time: hit, fill into a vacant way, or PLRU eviction (with writeback
//   of a Modified victim) followed by a bus read and fill.
//
//   Optional feature macro: LLC_STATS_EN adds saturating read/hit/miss
//   counters and the stat_* output ports.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       processor read handshake, req_addr = address
//   resp_valid                one-cycle completion pulse with
//   resp_hit/way/mesi         hit flag, way holding the line, final MESI
//   bus_valid/bus_ready       system bus handshake
//   bus_op/bus_addr           0=READ 1=WRITE, line address (offset zero)
//   bus_snoop                 NOHIT/HIT/HITM, sampled at READ handshake
//   msg_valid/type/addr       L1 message pulse: GETLINE/SENDLINE/EVICTLINE
//   lw_*                      side-port tag/MESI write (accepted in IDLE)
//   stat_reads/hits/misses    statistics (LLC_STATS_EN only)
module llc_read_engine #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6,
    parameter int WAYS     = 8,
    parameter int SETS     = 64,
    parameter int STAT_W   = 32,
    localparam int INDEX_W = $clog2(SETS),
    localparam int WAY_W   = $clog2(WAYS),
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               resp_valid,
    output logic               resp_hit,
    output logic [WAY_W-1:0]   resp_way,
    output logic [1:0]         resp_mesi,
    output logic               bus_valid,
    input  logic               bus_ready,
    output logic               bus_op,
    output logic [ADDR_W-1:0]  bus_addr,
    input  logic [1:0]         bus_snoop,
    output logic               msg_valid,
    output logic [1:0]         msg_type,
    output logic [ADDR_W-1:0]  msg_addr,
    input  logic               lw_valid,
    output logic               lw_ready,
    input  logic [INDEX_W-1:0] lw_index,
    input  logic [WAY_W-1:0]   lw_way,
    input  logic [TAG_W-1:0]   lw_tag,
    input  logic [1:0]         lw_mesi
`ifdef LLC_STATS_EN
    ,
    output logic [STAT_W-1:0]  stat_reads,
    output logic [STAT_W-1:0]  stat_hits,
    output logic [STAT_W-1:0]  stat_misses
`endif
);

    localparam int LINE_W = ADDR_W - OFFSET_W;

    localparam logic [1:0] MESI_I = 2'b00;
    localparam logic [1:0] MESI_S = 2'b01;
    localparam logic [1:0] MESI_E = 2'b10;
    localparam logic [1:0] MESI_M = 2'b11;

    localparam logic [1:0] SNOOP_NOHIT = 2'b00;

    localparam logic [1:0] MSG_GETLINE   = 2'b00;
    localparam logic [1:0] MSG_SENDLINE  = 2'b01;
    localparam logic [1:0] MSG_EVICTLINE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_GETL, S_WB, S_EVICT, S_BUSRD, S_FILL, S_RESP
    } state_t;

    state_t r_state, w_next;

    // cache arrays
    logic [TAG_W-1:0] r_tag  [SETS][WAYS];
    logic [1:0]       r_mesi [SETS][WAYS];
    logic             r_plru [SETS][WAYS-1];

    // transaction registers
    logic [LINE_W-1:0] r_line;
    logic [LINE_W-1:0] r_vline;
    logic [WAY_W-1:0]  r_way;
    logic              r_hit;
    logic              r_shared;

    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [ADDR_W-1:0]  w_req_addr;
    logic [ADDR_W-1:0]  w_vic_addr;

    logic               w_hit;
    logic [WAY_W-1:0]   w_hit_way;
    logic               w_has_inv;
    logic [WAY_W-1:0]   w_inv_way;
    logic [WAY_W-1:0]   w_vic_way;
    logic               w_vic_m;
    logic [WAY_W-1:0]   w_vnode;
    logic               w_vbit;

    logic               w_plru_upd [WAYS-1];
    logic [WAY_W-1:0]   w_unode;
    logic [WAY_W-1:0]   w_upath;
    logic               w_ubit;

    logic               w_accept;
    logic               w_unused_offset;

    assign w_unused_offset = ^req_addr[OFFSET_W-1:0];

    assign w_idx      = r_line[INDEX_W-1:0];
    assign w_tag      = r_line[LINE_W-1:INDEX_W];
    assign w_req_addr = {r_line, {OFFSET_W{1'b0}}};
    assign w_vic_addr = {r_vline, {OFFSET_W{1'b0}}};
    assign w_accept   = req_valid && req_ready;

    // tag match, lowest invalid way
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_has_inv = 1'b0;
        w_inv_way = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!w_hit && r_mesi[w_idx][i] != MESI_I && r_tag[w_idx][i] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(i);
            end
            if (!w_has_inv && r_mesi[w_idx][i] == MESI_I) begin
                w_has_inv = 1'b1;
                w_inv_way = WAY_W'(i);
            end
        end
    end

    // PLRU victim walk: each level contributes one way bit, MSB first
    always_comb begin
        w_vnode   = '0;
        w_vbit    = 1'b0;
        w_vic_way = '0;
        for (int unsigned l = 0; l < WAY_W; l++) begin
            w_vbit       = r_plru[w_idx][w_vnode];
            w_vic_way    = w_vic_way << 1;
            w_vic_way[0] = w_vbit;
            w_vnode      = (w_vnode << 1) + WAY_W'(1) + WAY_W'(w_vbit);
        end
        w_vic_m = (r_mesi[w_idx][w_vic_way] == MESI_M);
    end

    // PLRU touch of r_way: every node on the path points away from it
    always_comb begin
        w_plru_upd = r_plru[w_idx];
        w_unode    = '0;
        w_upath    = r_way;
        w_ubit     = 1'b0;
        for (int unsigned l = 0; l < WAY_W; l++) begin
            w_ubit              = w_upath[WAY_W-1];
            w_plru_upd[w_unode] = ~w_ubit;
            w_upath             = w_upath << 1;
            w_unode             = (w_unode << 1) + WAY_W'(1) + WAY_W'(w_ubit);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        lw_ready   = 1'b0;
        resp_valid = 1'b0;
        resp_hit   = 1'b0;
        resp_way   = '0;
        resp_mesi  = MESI_I;
        bus_valid  = 1'b0;
        bus_op     = 1'b0;
        bus_addr   = '0;
        msg_valid  = 1'b0;
        msg_type   = MSG_GETLINE;
        msg_addr   = '0;
        case (r_state)
            S_IDLE: begin
                lw_ready  = 1'b1;
                req_ready = ~lw_valid;
                if (req_valid && !lw_valid) w_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (w_hit)          w_next = S_RESP;
                else if (w_has_inv) w_next = S_BUSRD;
                else if (w_vic_m)   w_next = S_GETL;
                else                w_next = S_EVICT;
            end
            S_GETL: begin
                msg_valid = 1'b1;
                msg_type  = MSG_GETLINE;
                msg_addr  = w_vic_addr;
                w_next    = S_WB;
            end
            S_WB: begin
                bus_valid = 1'b1;
                bus_op    = 1'b1;
                bus_addr  = w_vic_addr;
                if (bus_ready) w_next = S_EVICT;
            end
            S_EVICT: begin
                msg_valid = 1'b1;
                msg_type  = MSG_EVICTLINE;
                msg_addr  = w_vic_addr;
                w_next    = S_BUSRD;
            end
            S_BUSRD: begin
                bus_valid = 1'b1;
                bus_op    = 1'b0;
                bus_addr  = w_req_addr;
                if (bus_ready) w_next = S_FILL;
            end
            S_FILL: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_hit   = r_hit;
                resp_way   = r_way;
                resp_mesi  = r_mesi[w_idx][r_way];
                msg_valid  = 1'b1;
                msg_type   = MSG_SENDLINE;
                msg_addr   = w_req_addr;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line   <= '0;
            r_vline  <= '0;
            r_way    <= '0;
            r_hit    <= 1'b0;
            r_shared <= 1'b0;
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    r_tag[s][w]  <= '0;
                    r_mesi[s][w] <= MESI_I;
                end
                for (int unsigned n = 0; n < WAYS - 1; n++) begin
                    r_plru[s][n] <= 1'b0;
                end
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (lw_valid) begin
                        r_tag[lw_index][lw_way]  <= lw_tag;
                        r_mesi[lw_index][lw_way] <= lw_mesi;
                    end else if (req_valid) begin
                        r_line <= req_addr[ADDR_W-1:OFFSET_W];
                    end
                end
                S_LOOKUP: begin
                    r_hit <= w_hit;
                    if (w_hit) begin
                        r_way <= w_hit_way;
                    end else if (w_has_inv) begin
                        r_way <= w_inv_way;
                    end else begin
                        r_way   <= w_vic_way;
                        r_vline <= {r_tag[w_idx][w_vic_way], w_idx};
                    end
                end
                S_EVICT: r_mesi[w_idx][r_way] <= MESI_I;
                S_BUSRD: if (bus_ready) r_shared <= (bus_snoop != SNOOP_NOHIT);
                S_FILL: begin
                    r_tag[w_idx][r_way]  <= w_tag;
                    r_mesi[w_idx][r_way] <= r_shared ? MESI_S : MESI_E;
                end
                S_RESP: r_plru[w_idx] <= w_plru_upd;
                default: ;
            endcase
        end
    end

`ifdef LLC_STATS_EN
    logic [STAT_W-1:0] r_stat_reads, r_stat_hits, r_stat_misses;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_reads  <= '0;
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
        end else begin
            if (w_accept && r_stat_reads != '1) r_stat_reads <= r_stat_reads + 1'b1;
            if (r_state == S_LOOKUP) begin
                if (w_hit) begin
                    if (r_stat_hits != '1) r_stat_hits <= r_stat_hits + 1'b1;
                end else begin
                    if (r_stat_misses != '1) r_stat_misses <= r_stat_misses + 1'b1;
                end
            end
        end
    end

    assign stat_reads  = r_stat_reads;
    assign stat_hits   = r_stat_hits;
    assign stat_misses = r_stat_misses;
`else
    logic              w_unused_accept;
    logic [STAT_W-1:0] w_unused_stat;
    assign w_unused_accept = w_accept;
    assign w_unused_stat   = '0;
`endif

endmodule

// File: tb/tb_llc_read_engine.sv
module tb_llc_read_engine;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 6;
    localparam int WAYS     = 4;
    localparam int SETS     = 16;
    localparam int STAT_W   = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        resp_valid, resp_hit;
    logic [1:0]  resp_way, resp_mesi;
    logic        bus_valid, bus_op;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_addr;
    logic [1:0]  bus_snoop = 2'b00;
    logic        msg_valid;
    logic [1:0]  msg_type;
    logic [31:0] msg_addr;
    logic        lw_valid = 1'b0;
    logic        lw_ready;
    logic [3:0]  lw_index = '0;
    logic [1:0]  lw_way = '0;
    logic [21:0] lw_tag = '0;
    logic [1:0]  lw_mesi = '0;
`ifdef LLC_STATS_EN
    logic [31:0] stat_reads, stat_hits, stat_misses;
`endif

    always #5 clk = ~clk;

    llc_read_engine #(
        .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .WAYS(WAYS), .SETS(SETS), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way), .resp_mesi(resp_mesi),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_op(bus_op), .bus_addr(bus_addr),
        .bus_snoop(bus_snoop),
        .msg_valid(msg_valid), .msg_type(msg_type), .msg_addr(msg_addr),
        .lw_valid(lw_valid), .lw_ready(lw_ready), .lw_index(lw_index), .lw_way(lw_way),
        .lw_tag(lw_tag), .lw_mesi(lw_mesi)
`ifdef LLC_STATS_EN
        , .stat_reads(stat_reads), .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
    );

    // expected event: kind 0 = L1 message, 1 = bus handshake, 2 = response
    typedef struct {
        int         kind;
        logic [1:0] typ;
        logic [31:0] addr;
        logic       hit;
        logic [1:0] way;
        logic [1:0] mesi;
    } ev_t;
    ev_t exp_q[$];

    int checks = 0;
    int failures = 0;
    bit hold_bus = 1'b0;

    // reference cache state
    logic [1:0]  m_mesi [16][4];
    logic [21:0] m_tag  [16][4];
    bit          m_plru [16][3];
    int m_reads = 0, m_hits = 0, m_misses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 4; w++) begin
                m_mesi[s][w] = 2'b00;
                m_tag[s][w]  = '0;
            end
            for (int n = 0; n < 3; n++) m_plru[s][n] = 1'b0;
        end
        m_reads = 0; m_hits = 0; m_misses = 0;
    endfunction

    function automatic int model_victim(int idx);
        int node = 0;
        int way = 0;
        for (int lv = 0; lv < 2; lv++) begin
            int b = int'(m_plru[idx][node]);
            way  = way * 2 + b;
            node = 2 * node + 1 + b;
        end
        return way;
    endfunction

    function automatic void plru_touch(int idx, int way);
        int node = 0;
        for (int lv = 0; lv < 2; lv++) begin
            int b = (way >> (1 - lv)) & 1;
            m_plru[idx][node] = (b == 0);
            node = 2 * node + 1 + b;
        end
    endfunction

    function automatic void push(int k, logic [1:0] t, logic [31:0] a,
                                 logic h, logic [1:0] w, logic [1:0] me);
        ev_t e;
        e.kind = k; e.typ = t; e.addr = a; e.hit = h; e.way = w; e.mesi = me;
        exp_q.push_back(e);
    endfunction

    // returns 1 when the read is expected to hit
    function automatic bit predict(logic [31:0] a, logic [1:0] snoop);
        logic [3:0]  idx  = a[9:6];
        logic [21:0] tg   = a[31:10];
        logic [31:0] line = {a[31:6], 6'b0};
        logic [31:0] vline;
        int way = -1;
        m_reads++;
        for (int w = 0; w < 4; w++)
            if (way < 0 && m_mesi[idx][w] != 2'b00 && m_tag[idx][w] == tg) way = w;
        if (way >= 0) begin
            m_hits++;
            push(0, 2'b01, line, 0, 0, 0);
            push(2, 0, 0, 1'b1, 2'(way), m_mesi[idx][way]);
            plru_touch(int'(idx), way);
            return 1'b1;
        end
        m_misses++;
        for (int w = 0; w < 4; w++)
            if (way < 0 && m_mesi[idx][w] == 2'b00) way = w;
        if (way < 0) begin
            way = model_victim(int'(idx));
            vline = {m_tag[idx][way], idx, 6'b0};
            if (m_mesi[idx][way] == 2'b11) begin
                push(0, 2'b00, vline, 0, 0, 0);
                push(1, 2'b01, vline, 0, 0, 0);
            end
            push(0, 2'b10, vline, 0, 0, 0);
            m_mesi[idx][way] = 2'b00;
        end
        push(1, 2'b00, line, 0, 0, 0);
        m_tag[idx][way]  = tg;
        m_mesi[idx][way] = (snoop == 2'b00) ? 2'b10 : 2'b01;
        push(0, 2'b01, line, 0, 0, 0);
        push(2, 0, 0, 1'b0, 2'(way), m_mesi[idx][way]);
        plru_touch(int'(idx), way);
        return 1'b0;
    endfunction

    // bus ready jitter, driven after the stimulus slot
    initial begin
        forever begin
            @(posedge clk);
            #2;
            bus_ready = hold_bus ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // monitor / scoreboard
    int cyc = 0;
    int rd_cyc = 0;
    bit prev_wait = 1'b0;
    logic prev_op;
    logic [31:0] prev_addr;

    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_wait = 1'b0;
            end else begin
                if (prev_wait) begin
                    chk("bus_hold_valid", bus_valid, 1);
                    chk("bus_hold_op", bus_op, prev_op);
                    chk("bus_hold_addr", bus_addr, prev_addr);
                end
                if (bus_valid && bus_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL bus_unexpected actual op=%0d addr=%0h required none", bus_op, bus_addr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("bus_evt_kind", 1, e.kind);
                        if (e.kind == 1) begin
                            chk("bus_op", bus_op, e.typ[0]);
                            chk("bus_addr", bus_addr, e.addr);
                        end
                        if (!bus_op) rd_cyc = cyc;
                    end
                end
                if (msg_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL msg_unexpected actual type=%0d addr=%0h required none", msg_type, msg_addr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("msg_evt_kind", 0, e.kind);
                        if (e.kind == 0) begin
                            chk("msg_type", msg_type, e.typ);
                            chk("msg_addr", msg_addr, e.addr);
                        end
                    end
                end
                if (resp_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL resp_unexpected actual way=%0d required none", resp_way);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_evt_kind", 2, e.kind);
                        if (e.kind == 2) begin
                            chk("resp_hit", resp_hit, e.hit);
                            chk("resp_way", resp_way, e.way);
                            chk("resp_mesi", resp_mesi, e.mesi);
                            if (!e.hit) chk("miss_resp_latency", cyc - rd_cyc, 2);
                        end
                    end
                end
                prev_wait = bus_valid && !bus_ready;
                prev_op   = bus_op;
                prev_addr = bus_addr;
            end
        end
    end

    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [1:0] snoop);
        bit exp_hit, ok, got, saw_bus;
        int n;
        chk("leftover_events", exp_q.size(), 0);
        bus_snoop = snoop;
        exp_hit   = predict(a, snoop);
        req_addr  = a;
        req_valid = 1'b1;
        wait_accept(ok);
        chk("req_accept", ok, 1);
        n = 0; got = 1'b0; saw_bus = 1'b0;
        if (ok) begin
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                n++;
                if (bus_valid) saw_bus = 1'b1;
                if (resp_valid) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("resp_seen", got, 1);
            if (exp_hit) begin
                chk("hit_latency", n, 2);
                chk("hit_no_bus", saw_bus, 0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic lw_write(input logic [3:0] idx, input logic [1:0] way, input logic [21:0] tg,
                            input logic [1:0] me, input bit with_req, input logic [31:0] a);
        lw_valid = 1'b1; lw_index = idx; lw_way = way; lw_tag = tg; lw_mesi = me;
        req_valid = with_req; req_addr = a;
        @(negedge clk);
        chk("lw_ready", lw_ready, 1);
        if (with_req) chk("req_blocked_by_lw", req_ready, 0);
        @(posedge clk);
        #1 lw_valid = 1'b0; req_valid = 1'b0;
        m_tag[idx][way]  = tg;
        m_mesi[idx][way] = me;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, seen;
        int v;
        model_reset();
        #1 rst = 1'b1;
        #2;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_lw_ready", lw_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_mesi", resp_mesi, 0);
        chk("rst_bus_valid", bus_valid, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_msg_valid", msg_valid, 0);
`ifdef LLC_STATS_EN
        chk("rst_stat_reads", stat_reads, 0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        // cold fill, hit, shared fill
        do_read(32'h0000_0040, 2'b00);
        do_read(32'h0000_0044, 2'b01);
        do_read(32'h0000_0480, 2'b10);
        do_read(32'h0000_0480, 2'b00);

        // clean victim in set 1
        do_reset();
        do_read(32'h0000_0440, 2'b00);
        do_read(32'h0000_0840, 2'b00);
        do_read(32'h0000_0C40, 2'b00);
        do_read(32'h0000_1040, 2'b00);
        do_read(32'h0000_1440, 2'b00);

        // Modified victim via side port, with a blocked request alongside
        v = model_victim(1);
        lw_write(4'd1, 2'(v), m_tag[1][v], 2'b11, 1'b1, 32'h0000_1840);
        do_read(32'h0000_1840, 2'b00);

        // reset while the bus read is outstanding
        hold_bus = 1'b1;
        bus_snoop = 2'b00;
        void'(predict(32'h0000_2080, 2'b00));
        req_addr = 32'h0000_2080;
        req_valid = 1'b1;
        wait_accept(ok);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("busrd_reached", seen, 1);
        rst = 1'b1;
        #1;
        chk("midrst_bus_valid", bus_valid, 0);
        chk("midrst_bus_addr", bus_addr, 0);
        chk("midrst_req_ready", req_ready, 1);
`ifdef LLC_STATS_EN
        chk("midrst_stat_reads", stat_reads, 0);
        chk("midrst_stat_hits", stat_hits, 0);
        chk("midrst_stat_misses", stat_misses, 0);
`endif
        exp_q.delete();
        model_reset();
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        hold_bus = 1'b0;
        do_read(32'h0000_2080, 2'b01);

        // randomized mix of reads and side-port writes on a few sets
        for (int k = 0; k < 150; k++) begin
            logic [3:0]  idx = 4'($urandom_range(0, 3));
            logic [21:0] tg  = 22'($urandom_range(0, 5));
            if ($urandom_range(0, 4) == 0) begin
                logic [1:0] w  = 2'($urandom_range(0, 3));
                logic [1:0] me = 2'($urandom_range(0, 3));
                for (int j = 0; j < 4; j++)
                    if (j != int'(w) && m_mesi[idx][j] != 2'b00 && m_tag[idx][j] == tg) me = 2'b00;
                lw_write(idx, w, tg, me, 1'($urandom_range(0, 1)), $urandom);
            end else begin
                do_read({tg, idx, 6'($urandom_range(0, 63))}, 2'($urandom_range(0, 2)));
            end
        end

        repeat (2) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
`ifdef LLC_STATS_EN
        chk("stat_reads", stat_reads, m_reads);
        chk("stat_hits", stat_hits, m_hits);
        chk("stat_misses", stat_misses, m_misses);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
